pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Sequencer for the F-stage PC register.
- Each cycle it decides among: reset hold, exception entry, ERET return, a latched branch redirect, a live branch redirect, sequential PC+4, or hold.
- Drives the PC register's next value (npc), load enable (pc_en) and exception-entry strobe (req).
- Handles the instruction-memory ready handshake; branch targets that resolve while fetch cannot advance are buffered.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; used for PC+4 arithmetic reference only.
- PC_EXC, 32'h0000_4180, exception handler entry. The PC register loads it itself on req; npc is don't-care that cycle.
- CNT_W, 32, width of the redirect_cnt performance counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- pc  in  32  current F-stage PC register value
- stall  in  1  hazard-unit stall of F/D
- imem_ready  in  1  instruction memory has returned the word at pc this cycle
- br_taken  in  1  D-stage branch/jump resolved taken
- br_target  in  32  D-stage redirect target
- exc_req  in  1  exception/interrupt committing in M this cycle
- eret  in  1  ERET committing in M this cycle
- epc  in  32  CP0 EPC value
- npc  out  32  next PC to load
- pc_en  out  1  PC register load enable
- req  out  1  force PC to PC_EXC
- flush  out  1  clear D/E/M pipeline registers
- redirect_cnt  out  CNT_W  count of applied redirects

Behaviour:
- Reset (synchronous, active-high):
  - state=RUN, pend_valid=0, pend_target=0, redirect_cnt=0.
  - While reset is high, outputs are req=0, flush=0, pc_en=0, npc=pc+4.
- Definition: advance = imem_ready & ~stall.
- States:
  - RUN: normal operation.
  - WAIT: entered when imem_ready=0 in RUN or WAIT. Fetch is outstanding.
  - REDIR: exactly one cycle after any exc_req or eret.
- Output priority (combinational, evaluated top down):
  1. exc_req=1: req=1, flush=1, pc_en=0. Applies in any state and ignores stall and imem_ready; the in-flight fetch is abandoned.
  2. eret=1 (with exc_req=0): npc=epc, pc_en=1, flush=1. Ignores stall and imem_ready.
  3. REDIR state: br_taken is ignored (the D instruction is flushed garbage). pc_en=advance, npc=pc+4.
  4. pend_valid=1: npc=pend_target, pc_en=advance.
  5. br_taken=1: npc=br_target, pc_en=advance.
  6. Otherwise: npc=pc+4, pc_en=advance.
- Pending register:
  - Set when br_taken=1, advance=0, not in REDIR, and no exc_req/eret that cycle. Sets pend_valid=1 and pend_target=br_target.
  - A re-asserted br_taken while pend_valid=1 overwrites pend_target with the newer value (same branch held in D).
  - Cleared when the pending target is applied (pc_en=1 with source 4), and on exc_req, eret or reset.
- State transitions:
  - Any state with exc_req|eret → REDIR.
  - REDIR → WAIT if imem_ready=0, else RUN.
  - RUN/WAIT → WAIT if imem_ready=0, else RUN.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- redirect_cnt:
  - Increments by 1 on each cycle where req=1, where eret drives pc_en, or where a branch/pending target is loaded with pc_en=1.
  - Never increments during reset.
  - Wraps at 2^CNT_W.
- Simultaneous events:
  - exc_req with eret: exception wins, eret is ignored.
  - exc_req or eret with br_taken: branch is dropped and not latched.
  - Reset in the middle of WAIT or REDIR, or with pend_valid set: everything clears the next edge; no redirect survives.
- Latency:
  - A branch applied with advance=1 is visible on pc one edge later.
  - A branch applied while stalled becomes visible one edge after the first cycle with advance=1.

Test Plan:
- reset=1 for 2 cycles, then imem_ready=1, stall=0, pc=0x3000 → pc_en=1, npc=0x3004, req=0, redirect_cnt=0.
- pc=0x3008, br_taken=1, br_target=0x3100, imem_ready=0 for 3 cycles then 1 (br_taken deasserted after cycle 1):
  - pc_en=0 while imem_ready=0.
  - pend_valid=1 during the wait.
  - First ready cycle: npc=0x3100, pc_en=1, redirect_cnt=1.
- exc_req=1 together with stall=1, imem_ready=0, br_taken=1 (target 0x3200):
  - Same cycle: req=1, flush=1, pc_en=0.
  - Next cycle: state REDIR, br_taken=1 is ignored, npc=pc+4.
  - No pending target is recorded.
- eret=1, epc=0x3050, stall=1 → npc=0x3050, pc_en=1, flush=1. Next cycle is REDIR.
- exc_req=1 and eret=1 in the same cycle → req=1, pc_en=0, redirect_cnt increments by exactly 1.
- Pending target set (0x3400), then reset asserted for 1 cycle → pend_valid=0. First advance after reset gives npc=pc+4, not 0x3400. Separately, pc=0xFFFF_FFFC, advance=1 → npc=0x0000_0000.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Picks the next F-stage PC each cycle, in priority order: reset hold,
//   exception entry, ERET return, post-redirect sequential fetch, buffered
//   branch target, live branch target, PC+4. Also drives the PC load
//   enable, the exception strobe and the pipeline flush. A branch that
//   resolves while fetch cannot advance is held until fetch can advance.
//
// Ports
//   clk_i           system clock, rising edge
//   reset_i         synchronous, active-high reset
//   pc_i            current F-stage PC register value
//   stall_i         hazard-unit stall of F/D
//   imem_ready_i    instruction word at pc_i returned this cycle
//   br_taken_i      D-stage branch/jump resolved taken
//   br_target_i     D-stage redirect target
//   exc_req_i       exception/interrupt committing in M
//   eret_i          ERET committing in M
//   epc_i           CP0 EPC value
//   npc_o           next PC to load
//   pc_en_o         PC register load enable
//   req_o           force PC to PC_EXC (the PC register loads it itself)
//   flush_o         clear D/E/M pipeline registers
//   redirect_cnt_o  count of applied redirects
module pc_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_EXC   = 32'h0000_4180,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [31:0]      pc_i,
    input  logic             stall_i,
    input  logic             imem_ready_i,
    input  logic             br_taken_i,
    input  logic [31:0]      br_target_i,
    input  logic             exc_req_i,
    input  logic             eret_i,
    input  logic [31:0]      epc_i,
    output logic [31:0]      npc_o,
    output logic             pc_en_o,
    output logic             req_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      pend_target_q, pend_target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        advance;
    logic [31:0] pc_plus4;
    logic        tgt_load;   // branch or buffered target selected this cycle
    logic        redirect;   // cycle counts toward redirect_cnt
    logic        in_redir;

    assign advance  = imem_ready_i & ~stall_i;
    assign pc_plus4 = pc_i + 32'd4;   // wraps modulo 2^32
    assign in_redir = (state_q == ST_REDIR);

    always_comb begin
        npc_o    = pc_plus4;
        pc_en_o  = 1'b0;
        req_o    = 1'b0;
        flush_o  = 1'b0;
        tgt_load = 1'b0;
        if (reset_i) begin
            npc_o = pc_plus4;
        end else if (exc_req_i) begin
            // Handler address comes from the PC register itself; fetch abandoned.
            req_o   = 1'b1;
            flush_o = 1'b1;
        end else if (eret_i) begin
            npc_o   = epc_i;
            pc_en_o = 1'b1;
            flush_o = 1'b1;
        end else if (in_redir) begin
            // D holds a flushed instruction; its branch outcome is garbage.
            pc_en_o = advance;
        end else if (pend_valid_q) begin
            npc_o    = pend_target_q;
            pc_en_o  = advance;
            tgt_load = 1'b1;
        end else if (br_taken_i) begin
            npc_o    = br_target_i;
            pc_en_o  = advance;
            tgt_load = 1'b1;
        end else begin
            pc_en_o = advance;
        end
    end

    assign redirect = req_o | (eret_i & ~exc_req_i & ~reset_i) | (tgt_load & pc_en_o);

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (exc_req_i | eret_i) begin
            pend_valid_d = 1'b0;
        end else if (!in_redir && br_taken_i && !advance) begin
            // Newer assertion of the same held branch overwrites the target.
            pend_valid_d  = 1'b1;
            pend_target_d = br_target_i;
        end else if (pend_valid_q && advance && !in_redir) begin
            pend_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = imem_ready_i ? ST_RUN : ST_WAIT;
        if (exc_req_i | eret_i)
            state_d = ST_REDIR;
    end

    assign cnt_d = redirect ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_RUN;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            cnt_q         <= cnt_d;
        end
    end

    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl. Inputs are driven 1 time unit after the
// rising edge and outputs sampled 1 unit later, well clear of the edge.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, imem_ready, br_taken, exc_req, eret;
    logic [31:0] pc, br_target, epc;
    logic [31:0] npc;
    logic        pc_en, req, flush;
    logic [31:0] redirect_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .pc_i           (pc),
        .stall_i        (stall),
        .imem_ready_i   (imem_ready),
        .br_taken_i     (br_taken),
        .br_target_i    (br_target),
        .exc_req_i      (exc_req),
        .eret_i         (eret),
        .epc_i          (epc),
        .npc_o          (npc),
        .pc_en_o        (pc_en),
        .req_o          (req),
        .flush_o        (flush),
        .redirect_cnt_o (redirect_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; br_taken = 1'b0;
        exc_req = 1'b0; eret = 1'b0; pc = 32'h3000; br_target = '0; epc = '0;

        // Reset for two cycles
        tick(); settle();
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_req",   {31'd0, req},   32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_npc",   npc, 32'h3004);
        tick();
        chk("rst_cnt", redirect_cnt, 32'd0);

        // Normal sequential fetch
        reset = 1'b0; imem_ready = 1'b1; settle();
        chk("seq_pc_en", {31'd0, pc_en}, 32'd1);
        chk("seq_npc",   npc, 32'h3004);
        chk("seq_req",   {31'd0, req}, 32'd0);
        chk("seq_cnt",   redirect_cnt, 32'd0);
        tick();

        // Branch during outstanding fetch: buffered, applied on first ready cycle
        pc = 32'h3008; br_taken = 1'b1; br_target = 32'h3100; imem_ready = 1'b0; settle();
        chk("pend_c1_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        br_taken = 1'b0; settle();
        chk("pend_c2_valid", {31'd0, dut.pend_valid_q}, 32'd1);
        chk("pend_c2_pc_en", {31'd0, pc_en}, 32'd0);
        tick(); settle();
        chk("pend_c3_pc_en", {31'd0, pc_en}, 32'd0);
        chk("pend_c3_valid", {31'd0, dut.pend_valid_q}, 32'd1);
        tick();
        imem_ready = 1'b1; settle();
        chk("pend_apply_npc",   npc, 32'h3100);
        chk("pend_apply_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        chk("pend_apply_cnt",   redirect_cnt, 32'd1);
        chk("pend_cleared",     {31'd0, dut.pend_valid_q}, 32'd0);

        // Exception beats stall, not-ready and a taken branch
        pc = 32'h3100; exc_req = 1'b1; stall = 1'b1; imem_ready = 1'b0;
        br_taken = 1'b1; br_target = 32'h3200; settle();
        chk("exc_req",   {31'd0, req},   32'd1);
        chk("exc_flush", {31'd0, flush}, 32'd1);
        chk("exc_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        chk("exc_cnt",   redirect_cnt, 32'd2);
        chk("exc_state", {30'd0, dut.state_q}, 32'd2);
        chk("exc_nopend", {31'd0, dut.pend_valid_q}, 32'd0);
        // REDIR cycle: branch still asserted but ignored
        exc_req = 1'b0; stall = 1'b0; imem_ready = 1'b1; pc = 32'h4180; settle();
        chk("redir_npc",   npc, 32'h4184);
        chk("redir_pc_en", {31'd0, pc_en}, 32'd1);
        chk("redir_flush", {31'd0, flush}, 32'd0);
        tick();
        chk("redir_cnt",    redirect_cnt, 32'd2);
        chk("redir_nopend", {31'd0, dut.pend_valid_q}, 32'd0);
        chk("redir_to_run", {30'd0, dut.state_q}, 32'd0);

        // ERET ignores stall
        br_taken = 1'b0; eret = 1'b1; epc = 32'h3050; stall = 1'b1; pc = 32'h4184; settle();
        chk("eret_npc",   npc, 32'h3050);
        chk("eret_pc_en", {31'd0, pc_en}, 32'd1);
        chk("eret_flush", {31'd0, flush}, 32'd1);
        chk("eret_req",   {31'd0, req},   32'd0);
        tick();
        chk("eret_cnt",   redirect_cnt, 32'd3);
        chk("eret_state", {30'd0, dut.state_q}, 32'd2);
        eret = 1'b0; stall = 1'b0; pc = 32'h3050; settle();
        chk("eret_redir_npc", npc, 32'h3054);
        tick();

        // Exception and ERET together: exception wins, single count
        exc_req = 1'b1; eret = 1'b1; settle();
        chk("both_req",   {31'd0, req},   32'd1);
        chk("both_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        chk("both_cnt", redirect_cnt, 32'd4);
        exc_req = 1'b0; eret = 1'b0; pc = 32'h4180; tick();

        // Pending target dropped by reset
        pc = 32'h4184; br_taken = 1'b1; br_target = 32'h3400; stall = 1'b1; settle();
        chk("pre_rst_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        chk("pre_rst_pend", {31'd0, dut.pend_valid_q}, 32'd1);
        reset = 1'b1; br_taken = 1'b0; settle();
        chk("mid_rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("mid_rst_npc",   npc, 32'h4188);
        tick();
        chk("post_rst_pend", {31'd0, dut.pend_valid_q}, 32'd0);
        chk("post_rst_cnt",  redirect_cnt, 32'd0);
        reset = 1'b0; stall = 1'b0; settle();
        chk("post_rst_npc",   npc, 32'h4188);
        chk("post_rst_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        chk("post_rst_cnt2", redirect_cnt, 32'd0);

        // Live branch with advance
        pc = 32'h3000; br_taken = 1'b1; br_target = 32'h3500; settle();
        chk("live_npc",   npc, 32'h3500);
        chk("live_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        chk("live_cnt",  redirect_cnt, 32'd1);
        chk("live_nopend", {31'd0, dut.pend_valid_q}, 32'd0);

        // PC+4 wrap
        br_taken = 1'b0; pc = 32'hFFFF_FFFC; settle();
        chk("wrap_npc",   npc, 32'h0000_0000);
        chk("wrap_pc_en", {31'd0, pc_en}, 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
